// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reset sequencer: state encoding, the loss
// counter width, and the decode from state to the registered control outputs.
package pll_ctrl_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ARST      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  typedef struct packed {
    logic areset;
    logic sys_rst_n;
    logic ready;
    logic fail;
  } pll_out_t;

  // Control outputs that belong to each state; unknown encodings decode to
  // the safe combination (PLL held in reset, system held in reset, fault).
  function automatic pll_out_t state_outputs(input pll_state_t st);
    pll_out_t o;
    o.areset    = 1'b1;
    o.sys_rst_n = 1'b0;
    o.ready     = 1'b0;
    o.fail      = 1'b0;
    case (st)
      ARST: begin
        o.areset = 1'b1;
      end
      WAIT_LOCK, STABLE: begin
        o.areset = 1'b0;
      end
      RUN: begin
        o.areset    = 1'b0;
        o.sys_rst_n = 1'b1;
        o.ready     = 1'b1;
      end
      FAIL: begin
        o.fail = 1'b1;
      end
      default: begin
        o.fail = 1'b1;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for bringing an asynchronous level
// into the clk domain. Both stages clear on the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two back-to-back capture stages to let metastability settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL bring-up sequencer running on the raw board clock. Pulses the PLL
// areset, waits for lock with a timeout and bounded retries, qualifies lock
// as stable, then releases the system reset. A lock loss in service goes to
// the sticky fault state, or, when PLL_RESET_CTRL_AUTO_RELOCK_EN is defined,
// reruns the complete bring-up sequence.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int ARESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int LOCK_STABLE   = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pll_locked,
  output logic                               pll_areset,
  output logic                               sys_rst_n,
  output logic                               pll_ready,
  output logic                               pll_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
  output logic [LOSS_CNT_W-1:0]              loss_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int ARST_W  = $clog2(ARESET_CYCLES + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int STAB_W  = $clog2(LOCK_STABLE + 1);

  pll_state_t              state_r;
  pll_out_t                out_r;
  logic [ARST_W-1:0]       arst_cnt_r;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic [STAB_W-1:0]       stab_cnt_r;
  logic [RETRY_W-1:0]      retry_cnt_r;
  logic [LOSS_CNT_W-1:0]   loss_cnt_r;
  logic                    locked_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Sequencer: state, per-state counters and the registered control outputs.
  // Each counter is cleared when its state is left, so every state is
  // entered with all counters at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ARST;
      out_r       <= state_outputs(ARST);
      arst_cnt_r  <= '0;
      tmo_cnt_r   <= '0;
      stab_cnt_r  <= '0;
      retry_cnt_r <= '0;
      loss_cnt_r  <= '0;
    end else begin
      case (state_r)
        ARST: begin
          if (arst_cnt_r == ARST_W'(ARESET_CYCLES - 1)) begin
            arst_cnt_r <= '0;
            state_r    <= WAIT_LOCK;
            out_r      <= state_outputs(WAIT_LOCK);
          end else begin
            arst_cnt_r <= arst_cnt_r + ARST_W'(1);
          end
        end

        WAIT_LOCK: begin
          // Lock takes priority over a timeout landing on the same cycle
          if (locked_s) begin
            tmo_cnt_r <= '0;
            state_r   <= STABLE;
            out_r     <= state_outputs(STABLE);
          end else if (tmo_cnt_r == TMO_W'(LOCK_TIMEOUT - 1)) begin
            tmo_cnt_r   <= '0;
            retry_cnt_r <= retry_cnt_r + RETRY_W'(1);
            if (retry_cnt_r == RETRY_W'(MAX_RETRY - 1)) begin
              state_r <= FAIL;
              out_r   <= state_outputs(FAIL);
            end else begin
              state_r <= ARST;
              out_r   <= state_outputs(ARST);
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end

        STABLE: begin
          // Any dropout restarts qualification from scratch
          if (!locked_s) begin
            stab_cnt_r <= '0;
            state_r    <= WAIT_LOCK;
            out_r      <= state_outputs(WAIT_LOCK);
          end else if (stab_cnt_r == STAB_W'(LOCK_STABLE - 1)) begin
            stab_cnt_r  <= '0;
            retry_cnt_r <= '0;
            state_r     <= RUN;
            out_r       <= state_outputs(RUN);
          end else begin
            stab_cnt_r <= stab_cnt_r + STAB_W'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            if (loss_cnt_r != {LOSS_CNT_W{1'b1}}) begin
              loss_cnt_r <= loss_cnt_r + LOSS_CNT_W'(1);
            end else begin
              loss_cnt_r <= loss_cnt_r;
            end
`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
            retry_cnt_r <= '0;
            state_r     <= ARST;
            out_r       <= state_outputs(ARST);
`else
            state_r <= FAIL;
            out_r   <= state_outputs(FAIL);
`endif
          end else begin
            state_r <= RUN;
          end
        end

        FAIL: begin
          // Sticky until rst
          state_r <= FAIL;
          out_r   <= state_outputs(FAIL);
        end

        default: begin
          state_r <= FAIL;
          out_r   <= state_outputs(FAIL);
        end
      endcase
    end
  end

  assign pll_areset = out_r.areset;
  assign sys_rst_n  = out_r.sys_rst_n;
  assign pll_ready  = out_r.ready;
  assign pll_fail   = out_r.fail;
  assign retry_cnt  = retry_cnt_r;
  assign loss_cnt   = loss_cnt_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl (ARESET_CYCLES=4, LOCK_TIMEOUT=20,
// LOCK_STABLE=8, MAX_RETRY=2). The stimulus process pushes each expected
// output change (cycle, tolerance, values) into a queue; the monitor pops
// and compares whenever the outputs change or a snapshot is requested.
module tb_pll_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_areset;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  pll_reset_ctrl #(
    .ARESET_CYCLES (4),
    .LOCK_TIMEOUT  (20),
    .LOCK_STABLE   (8),
    .MAX_RETRY     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_areset (pll_areset),
    .sys_rst_n  (sys_rst_n),
    .pll_ready  (pll_ready),
    .pll_fail   (pll_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ctl = {pll_areset, sys_rst_n, pll_ready, pll_fail}
  localparam logic [3:0] C_RST  = 4'b1000;
  localparam logic [3:0] C_WAIT = 4'b0000;
  localparam logic [3:0] C_RUN  = 4'b0110;
  localparam logic [3:0] C_FLT  = 4'b1001;

  typedef struct {
    int         at;
    int         tol;
    bit         snap;
    logic [3:0] ctl;
    logic [1:0] retry;
    logic [7:0] loss;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   snap_seq = 0;

  task automatic expect_ev(input int at, input int tol, input logic [3:0] ctl,
                           input logic [1:0] retry, input logic [7:0] loss,
                           input string name);
    exp_t e;
    e.at = at; e.tol = tol; e.snap = 1'b0;
    e.ctl = ctl; e.retry = retry; e.loss = loss; e.name = name;
    exp_q.push_back(e);
  endtask

  // Request a check of the values present after the next clock edge
  task automatic expect_snap(input logic [3:0] ctl, input logic [1:0] retry,
                             input logic [7:0] loss, input string name);
    exp_t e;
    e.at = cyc + 1; e.tol = 0; e.snap = 1'b1;
    e.ctl = ctl; e.retry = retry; e.loss = loss; e.name = name;
    exp_q.push_back(e);
    snap_seq++;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: compare each output change (or snapshot) against the queue head
  initial begin : monitor
    logic [13:0] prev;
    logic [13:0] cur;
    int          seen;
    bit          changed;
    bit          snap;
    exp_t        e;
    prev = 'x;
    seen = 0;
    forever begin
      @(posedge clk);
      #1;
      cur     = {pll_areset, sys_rst_n, pll_ready, pll_fail, retry_cnt, loss_cnt};
      changed = (cur !== prev);
      prev    = cur;
      snap    = (seen != snap_seq);
      seen    = snap_seq;
      if (changed || snap) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected: got ctl=%b retry=%0d loss=%0d at cycle %0d, want no change",
                   cur[13:10], cur[9:8], cur[7:0], cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur !== {e.ctl, e.retry, e.loss} || cyc < e.at - e.tol || cyc > e.at + e.tol) begin
            n_bad++;
            $display("FAIL %s: got ctl=%b retry=%0d loss=%0d at cycle %0d, want ctl=%b retry=%0d loss=%0d at cycle %0d+-%0d",
                     e.name, cur[13:10], cur[9:8], cur[7:0], cyc, e.ctl, e.retry, e.loss, e.at, e.tol);
          end
        end
      end else if (exp_q.size() > 0 && !exp_q[0].snap && cyc > exp_q[0].at + exp_q[0].tol) begin
        n_cmp++;
        n_bad++;
        e = exp_q.pop_front();
        $display("FAIL %s: got no change by cycle %0d, want ctl=%b retry=%0d loss=%0d at cycle %0d+-%0d",
                 e.name, cyc, e.ctl, e.retry, e.loss, e.at, e.tol);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got no end of stimulus by 50000 time units, want completion");
    $fatal(1);
  end

  // Stimulus: directed scenarios with hand-computed output change cycles
  initial begin : stimulus
    rst        = 1'b1;
    pll_locked = 1'b0;
    expect_ev(1, 0, C_RST, 2'd0, 8'd0, "reset_state");

    // Clean bring-up: areset high 4 cycles, release 11 cycles after lock
    tick_to(3);
    rst = 1'b0;
    expect_ev(7, 0, C_WAIT, 2'd0, 8'd0, "areset_len");
    tick_to(13);
    pll_locked = 1'b1;
    expect_ev(24, 1, C_RUN, 2'd0, 8'd0, "s1_release");

    // Lock loss in service
    tick_to(40);
    pll_locked = 1'b0;
`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
    expect_ev(43, 1, C_RST, 2'd0, 8'd1, "s4_loss");
    expect_ev(47, 0, C_WAIT, 2'd0, 8'd1, "s4_areset_len");
    tick_to(48);
    pll_locked = 1'b1;
    expect_ev(59, 1, C_RUN, 2'd0, 8'd1, "s4_relock");
`else
    expect_ev(43, 1, C_FLT, 2'd0, 8'd1, "s5_loss_fail");
    tick_to(50);
    pll_locked = 1'b1;
`endif

    // No lock at all: two timeouts, then sticky fault
    tick_to(90);
    rst        = 1'b1;
    pll_locked = 1'b0;
    expect_ev(91, 0, C_RST, 2'd0, 8'd0, "s2_rst");
    tick_to(92);
    rst = 1'b0;
    expect_ev(96, 0, C_WAIT, 2'd0, 8'd0, "s2_arst1");
    expect_ev(116, 0, C_RST, 2'd1, 8'd0, "s2_retry1");
    expect_ev(120, 0, C_WAIT, 2'd1, 8'd0, "s2_arst2");
    expect_ev(140, 0, C_FLT, 2'd2, 8'd0, "s2_fail");

    // One-cycle rst in FAIL restarts; one timeout, then a STABLE dropout
    tick_to(180);
    rst = 1'b1;
    expect_ev(181, 0, C_RST, 2'd0, 8'd0, "s6_rst_fail");
    tick_to(181);
    rst = 1'b0;
    expect_ev(185, 0, C_WAIT, 2'd0, 8'd0, "s6_restart");
    expect_ev(205, 0, C_RST, 2'd1, 8'd0, "s3_retry");
    expect_ev(209, 0, C_WAIT, 2'd1, 8'd0, "s3_wait");
    tick_to(211);
    pll_locked = 1'b1;
    tick_to(217);
    pll_locked = 1'b0;
    tick_to(218);
    pll_locked = 1'b1;
    tick_to(223);
    expect_snap(C_WAIT, 2'd1, 8'd0, "s3_retry_kept");
    expect_ev(229, 1, C_RUN, 2'd0, 8'd0, "s3_release");

    // One-cycle rst mid-STABLE
    tick_to(240);
    rst        = 1'b1;
    pll_locked = 1'b0;
    expect_ev(241, 0, C_RST, 2'd0, 8'd0, "s6_rst_run");
    tick_to(242);
    rst = 1'b0;
    tick_to(243);
    pll_locked = 1'b1;
    expect_ev(246, 0, C_WAIT, 2'd0, 8'd0, "s6_arst");
    tick_to(250);
    rst = 1'b1;
    expect_ev(251, 0, C_RST, 2'd0, 8'd0, "s6_rst_stable");
    tick_to(251);
    rst = 1'b0;
    expect_ev(255, 0, C_WAIT, 2'd0, 8'd0, "s6_restart2");
    expect_ev(264, 0, C_RUN, 2'd0, 8'd0, "s6_release");

    tick_to(300);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expected events outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Sequencer for the board PLL: drives the PLL `areset`, watches `locked`, and generates the system reset for all logic clocked from PLL outputs. It runs on the raw 50 MHz board clock, never on a PLL output. It retries on lock timeout, goes to a sticky fault after repeated failures, and optionally re-locks after a loss of lock in service. It sits beside the PLL instance at the top level; downstream blocks take `sys_rst_n` and `pll_ready`.

## Interface
- `ARESET_CYCLES`, default 16: cycles `pll_areset` is held high per reset attempt.
- `LOCK_TIMEOUT`, default 50000: cycles allowed in WAIT_LOCK (1 ms at 50 MHz).
- `LOCK_STABLE`, default 1024: consecutive synchronized `locked` samples required before release.
- `MAX_RETRY`, default 3: lock timeouts tolerated before FAIL.

Ports:
- `clk`  in  1  board reference clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL `locked`; asynchronous to `clk`.
- `pll_areset`  out  1  to the PLL `areset`; high holds the PLL in reset.
- `sys_rst_n`  out  1  active-low reset for the PLL-clocked domains.
- `pll_ready`  out  1  high only in RUN.
- `pll_fail`  out  1  sticky fault; high only in FAIL.
- `retry_cnt`  out  $clog2(MAX_RETRY+1)  lock timeouts in the current bring-up.
- `loss_cnt`  out  8  lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. All decisions use `locked_s` only.
- States:
  - **ARST**: `pll_areset`=1. Counts ARESET_CYCLES, then goes to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_areset`=0.
    - If `locked_s`=1, go to STABLE.
    - If the timeout counter reaches LOCK_TIMEOUT, increment `retry_cnt`.
    - If the new `retry_cnt` equals MAX_RETRY, go to FAIL; otherwise go to ARST.
  - **STABLE**: counts consecutive `locked_s`=1 samples.
    - If `locked_s`=0, go back to WAIT_LOCK. The stable counter clears; the timeout counter restarts at 0; `retry_cnt` is unchanged.
    - On reaching LOCK_STABLE, go to RUN.
  - **RUN**: `sys_rst_n`=1, `pll_ready`=1. If `locked_s`=0, `loss_cnt` increments (saturating), then the configured loss action applies (see Configuration).
  - **FAIL**: `pll_areset`=1, `sys_rst_n`=0, `pll_fail`=1. Left only by `rst`.
- `retry_cnt` clears on entry to RUN. `loss_cnt` clears only on `rst`.
- All outputs are registered.
- Counters are sized `$clog2` of their parameter + 1 and clear on every state entry.

## Timing
- During `rst` and on the first cycle after it:
  - state = ARST
  - `pll_areset`=1, `sys_rst_n`=0, `pll_ready`=0, `pll_fail`=0
  - `retry_cnt`=0, `loss_cnt`=0
- `pll_areset` stays high for exactly ARESET_CYCLES cycles after `rst` deasserts.
- `locked_s` lags `pll_locked` by 2 cycles (+1 for asynchronous arrival).
- `sys_rst_n` and `pll_ready` rise together, LOCK_STABLE+3 cycles after `pll_locked` rises (±1), given no dropout.
- On lock loss in RUN, `sys_rst_n` goes low 3 cycles after `pll_locked` falls (±1), on the same edge that `pll_ready` falls. No glitch is allowed.
- A dropout of 1 cycle or longer in `locked_s` during STABLE restarts the qualification in full.
- `rst` asserted in any state (including mid-count or FAIL) returns to the reset values on the next edge.
- When timeout and `locked_s` rising hit the same cycle in WAIT_LOCK, lock wins: go to STABLE, no retry increment.

## Configuration
- Macro `PLL_RESET_CTRL_AUTO_RELOCK_EN`.
- Defined: lock loss in RUN goes to ARST. The full sequence reruns, with `retry_cnt` starting at 0.
- Undefined: lock loss in RUN goes straight to FAIL. `loss_cnt` still increments, so it reads 1.

## Structure
- Package `pll_ctrl_pkg` holds:
  - the state enum `pll_state_t` (ARST, WAIT_LOCK, STABLE, RUN, FAIL)
  - the `loss_cnt` width constant `LOSS_CNT_W` = 8
- Sub-module `sync_2ff`: 1-bit 2-flop synchronizer, instantiated for `pll_locked`. It is reusable across the codebase.

## Test plan
Params for all scenarios unless noted: ARESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.
1. `rst` released, `pll_locked` rises 10 cycles later and stays high → `pll_areset` high 4 cycles; `sys_rst_n`/`pll_ready` rise 11 cycles (±1) after `pll_locked`; `retry_cnt`=0.
2. `pll_locked` held 0 → two ARST pulses of 4 cycles each, separated by 20-cycle waits; `retry_cnt` reaches 2; `pll_fail`=1 and `pll_areset`=1, held until `rst`.
3. In STABLE, `pll_locked` drops for 1 cycle after 5 good samples → `sys_rst_n` stays 0; release comes 8 full samples after recovery; `retry_cnt` unchanged.
4. In RUN with AUTO_RELOCK_EN defined, `pll_locked` drops → `pll_ready` and `sys_rst_n` fall 3 cycles later (±1); `loss_cnt`=1; `pll_areset` pulses 4 cycles; relock returns to RUN.
5. Same stimulus with the macro undefined → FAIL, `pll_fail`=1, `loss_cnt`=1, no re-release.
6. `rst` pulsed for 1 cycle mid-STABLE and again in FAIL → all outputs return to their reset values on the next edge and the sequence restarts from ARST.
